// File: rtl/zigzag_encryption.sv
// Rail-fence (zigzag) encryptor: buffers plaintext until the start token, then emits ciphertext in rail order.
// Optional sticky overflow flag output ovf_o is enabled by defining ZIGZAG_ENC_OVF_EN.
module zigzag_encryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
`ifdef ZIGZAG_ENC_OVF_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int PW = (KEY_WIDTH + 2 > 10) ? KEY_WIDTH + 2 : 10;

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       emitted_q, emitted_d;
  logic [PW-1:0]       key_q, key_d;
  logic [PW-1:0]       rail_q, rail_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                phase_q, phase_d;
  logic                wr_en;
  logic [D_WIDTH-1:0]  mem_q [MAX_NOF_CHARS];

  logic [PW-1:0]       period;
  logic [PW-1:0]       two_r;
  logic [PW-1:0]       step;
  logic [PW-1:0]       npos;

`ifdef ZIGZAG_ENC_OVF_EN
  logic                ovf_q, ovf_d;
  assign ovf_o = ovf_q;
`endif

  assign period = {key_q[PW-2:0], 1'b0} - PW'(2);
  assign two_r  = {rail_q[PW-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    emitted_d = emitted_q;
    key_d     = key_q;
    rail_d    = rail_q;
    pos_d     = pos_q;
    phase_d   = phase_q;
    wr_en     = 1'b0;
    step      = '0;
    npos      = '0;
`ifdef ZIGZAG_ENC_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      COLLECT: begin
        if (valid_i) begin
          if (data_i == START_ENCRYPTION_TOKEN) begin
            if (count_q != '0) begin
              state_d   = EMIT;
              key_d     = (key == '0) ? PW'(1) : PW'(key);
              rail_d    = '0;
              pos_d     = '0;
              phase_d   = 1'b0;
              emitted_d = '0;
            end
          end else if (count_q < CW'(MAX_NOF_CHARS)) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
`ifdef ZIGZAG_ENC_OVF_EN
            ovf_d = 1'b1;
`endif
          end
        end
      end
      EMIT: begin
        // A single rail has period 0; stepping by 1 yields the identity order.
        if (period == '0)
          step = PW'(1);
        else if (rail_q == '0 || rail_q == key_q - PW'(1))
          step = period;
        else if (phase_q)
          step = two_r;
        else
          step = period - two_r;
        npos      = pos_q + step;
        emitted_d = emitted_q + CW'(1);
        if (emitted_q == count_q - CW'(1)) begin
          state_d = COLLECT;
          count_d = '0;
`ifdef ZIGZAG_ENC_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else if (npos >= PW'(count_q)) begin
          rail_d  = rail_q + PW'(1);
          pos_d   = rail_q + PW'(1);
          phase_d = 1'b0;
        end else begin
          pos_d   = npos;
          phase_d = ~phase_q;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      emitted_q <= '0;
      key_q     <= PW'(1);
      rail_q    <= '0;
      pos_q     <= '0;
      phase_q   <= 1'b0;
`ifdef ZIGZAG_ENC_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      emitted_q <= emitted_d;
      key_q     <= key_d;
      rail_q    <= rail_d;
      pos_q     <= pos_d;
      phase_q   <= phase_d;
`ifdef ZIGZAG_ENC_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= data_i;
  end

  // Outputs decode straight from state so an async reset clears them at once.
  assign busy    = (state_q == EMIT);
  assign valid_o = busy;
  assign data_o  = busy ? mem_q[pos_q[AW-1:0]] : '0;

endmodule

// File: tb/tb_zigzag_encryption.sv
// Scoreboard bench for zigzag_encryption: reference rail-fence model feeds an expectation queue.
module tb_zigzag_encryption;
  localparam logic [7:0] TOK = 8'hFA;
  localparam int MAXC = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;
`ifdef ZIGZAG_ENC_OVF_EN
  logic       ovf_o;
`endif

  zigzag_encryption #(
    .D_WIDTH(8), .KEY_WIDTH(8), .MAX_NOF_CHARS(MAXC), .START_ENCRYPTION_TOKEN(TOK)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .key(key),
    .busy(busy), .data_o(data_o), .valid_o(valid_o)
`ifdef ZIGZAG_ENC_OVF_EN
    , .ovf_o(ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  int cur_len = 0;
  int last_len = 0;
  int bursts = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops expectations on every output beat, tracks burst lengths.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", int'(busy), int'(valid_o));
      if (valid_o) begin
        cur_len++;
        if (exp_q.size() == 0) check("beat_without_expectation", exp_q.size(), 1);
        else check("cipher_char", int'(data_o), int'(exp_q.pop_front()));
      end else begin
        check("data_o_idle_zero", int'(data_o), 0);
        if (cur_len > 0) begin
          last_len = cur_len;
          cur_len  = 0;
          bursts++;
        end
      end
    end
  end

  // Reference: each position i sits on rail f(i mod cycle); rails are read out in order.
  task automatic push_model(input int k, input int stored);
    int kk, cyc, m, rr;
    kk = (k == 0) ? 1 : k;
    if (kk == 1) begin
      for (int i = 0; i < stored; i++) exp_q.push_back(pend_q[i]);
    end else begin
      cyc = 2 * kk - 2;
      for (int r = 0; r < kk && r < stored; r++)
        for (int i = 0; i < stored; i++) begin
          m  = i % cyc;
          rr = (m < kk) ? m : cyc - m;
          if (rr == r) exp_q.push_back(pend_q[i]);
        end
    end
  endtask

  task automatic load(input string s);
    pend_q.delete();
    for (int i = 0; i < s.len(); i++) pend_q.push_back(s[i]);
  endtask

  task automatic rand_msg(input int n);
    logic [7:0] c;
    pend_q.delete();
    for (int i = 0; i < n; i++) begin
      c = 8'($urandom_range(0, 255));
      if (c == TOK) c = 8'h41;
      pend_q.push_back(c);
    end
  endtask

  task automatic send(input logic [7:0] c);
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = TOK;
    end
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = c;
  endtask

  task automatic send_body(input int k);
    foreach (pend_q[i]) send(pend_q[i]);
    key = 8'(k);
    send(TOK);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'($urandom_range(0, 255));
    key     = 8'($urandom_range(0, 255));
  endtask

  task automatic run(input int k, input bit zmode);
    int n, stored, b0, cyc;
    bit ovf;
    n = pend_q.size();
    stored = (n > MAXC) ? MAXC : n;
    ovf = (n > MAXC);
    b0 = bursts;
    push_model(k, stored);
    send_body(k);
    for (cyc = 0; cyc < 300 && (busy || exp_q.size() != 0); cyc++) begin
      if (zmode) begin
        valid_i = busy;
        data_i  = "Z";
        key     = 8'($urandom_range(0, 255));
      end
`ifdef ZIGZAG_ENC_OVF_EN
      if (busy) check("ovf_sticky", int'(ovf_o), int'(ovf));
`endif
      @(negedge clk);
    end
    valid_i = 1'b0;
    if (cyc >= 300) begin
      checks++;
      failures++;
      $display("FAIL emit_timeout actual=%0d remaining required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check("burst_count", bursts - b0, (stored > 0) ? 1 : 0);
    if (stored > 0) check("burst_len", last_len, stored);
`ifdef ZIGZAG_ENC_OVF_EN
    check("ovf_cleared", int'(ovf_o), 0);
`endif
    pend_q.delete();
  endtask

  task automatic reset_mid_emit();
    rand_msg(10);
    push_model(3, 10);
    send_body(3);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_data_o", int'(data_o), 0);
    exp_q.delete();
    cur_len = 0;
    pend_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    data_i = '0;
    key = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_data_o", int'(data_o), 0);
`ifdef ZIGZAG_ENC_OVF_EN
    check("reset_ovf", int'(ovf_o), 0);
`endif
    rst = 1'b0;

    load("HELLOWORLD"); run(3, 0);
    load("ABCDE");      run(2, 0);
    load("ABC");        run(1, 0);
    load("ABC");        run(0, 0);
    load("ABC");        run(5, 0);
    pend_q.delete();    run(2, 0);
    load("XY");         run(2, 0);
    rand_msg(12);       run(4, 1);
    load("AB");         run(2, 0);
    pend_q.delete();
    for (int i = 0; i < 52; i++) pend_q.push_back(8'("a" + (i % 26)));
    run(1, 0);
    reset_mid_emit();
    load("AB");         run(2, 0);
    for (int t = 0; t < 25; t++) begin
      int kr, ln;
      kr = $urandom_range(0, 4);
      if (kr == 4) kr = $urandom_range(5, 255);
      ln = (t % 5 == 0) ? $urandom_range(45, 56) : $urandom_range(1, 20);
      rand_msg(ln);
      run(kr, (t % 3 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
